riscv_mc_ctrl: RTL
==================

# riscv_mc_ctrl

Multi-cycle control FSM for the RISC-V core: the sequencer that replaces single-cycle decode when instruction and data share one memory port with a ready handshake. Each instruction steps through fetch, decode, execute, memory and writeback states. The controller drives the PC/IR enables, mux selects, ALU opcode class and register/memory strobes for the shared datapath. It supports the same opcode set as the single-cycle decoder: load, store, R-type, I-type ALU, LUI and branch.

## Interface
Parameters:
- none (opcodes and encodings are package constants)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  7  opcode field, taken from the instruction register (valid from DECODE onward)
- zero  in  1  ALU zero flag, used by the branch decision
- mem_ack  in  1  memory completed the current request this cycle
- mem_req  out  1  memory access request, held until mem_ack
- mem_write  out  1  request is a write (store)
- mem_read  out  1  request is a read (fetch or load)
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- reg_write  out  1  register file write enable
- alu_src_a  out  2  ALU A select: 0 = PC, 1 = rs1, 2 = old PC
- alu_src_b  out  2  ALU B select: 0 = rs2, 1 = immediate, 2 = constant 4
- alu_op  out  2  00 = add, 01 = branch compare (sub), 10 = funct-decoded
- result_src  out  2  writeback select: 0 = ALU result register, 1 = memory data, 2 = immediate (LUI)
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  sticky unsupported-opcode flag

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, LUIWB, TRAP.
- FETCH:
  - mem_req=1, mem_read=1, adr_src=0, alu_src_a=0, alu_src_b=2, alu_op=00.
  - On mem_ack: ir_write=1, pc_write=1 (PC+4), then go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=2, alu_src_b=1, alu_op=00 (branch target precompute). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 0110111 → LUIWB
  - any other opcode → TRAP
- MEMADR: alu_src_a=1, alu_src_b=1, alu_op=00. Go to MEMRD if load, MEMWR if store.
- MEMRD: mem_req=1, mem_read=1, adr_src=1. On mem_ack go to MEMWB.
- MEMWB: reg_write=1, result_src=1, instr_done=1, then go to FETCH.
- MEMWR: mem_req=1, mem_write=1, adr_src=1. On mem_ack: instr_done=1, then go to FETCH.
- EXECR: alu_src_a=1, alu_src_b=0, alu_op=10, then go to ALUWB.
- EXECI: alu_src_a=1, alu_src_b=1, alu_op=10, then go to ALUWB.
- ALUWB: reg_write=1, result_src=0, instr_done=1, then go to FETCH.
- BEQ: alu_src_a=1, alu_src_b=0, alu_op=01, pc_write=zero, instr_done=1, then go to FETCH.
- LUIWB: reg_write=1, result_src=2, instr_done=1, then go to FETCH.
- TRAP: illegal=1. All strobes stay 0. The FSM remains in TRAP until rst.
- Any output not listed for a state is 0.

## Timing
- Reset:
  - rst high forces every output to 0 and sets the state to FETCH.
  - mem_req rises in the first cycle after rst drops.
- Reset mid-operation: abandons the instruction immediately.
  - An outstanding mem_req is dropped without waiting for mem_ack.
  - No reg_write or pc_write is issued in the rst cycle.
- Handshake:
  - mem_req, mem_read, mem_write and adr_src stay stable from the cycle mem_req asserts through the mem_ack cycle.
  - Zero-wait memory may assert mem_ack in the same cycle mem_req rises.
  - mem_ack while mem_req=0 is ignored.
- Latency with zero-wait memory: load 5, store 4, R/I 4, LUI 3, branch 3 cycles. Each wait cycle of memory adds one cycle per access.
- Strobes are combinational from state (plus mem_ack/zero for pc_write, ir_write and the MEMWR instr_done). Registers update on the next clk edge.
- instr_done is never asserted in TRAP or during rst.

## Structure
- Package riscv_mc_pkg holds:
  - the state enum (4-bit)
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_LUI, OP_BRANCH
  - select encodings for alu_src_a, alu_src_b, result_src and alu_op
- One sub-module: riscv_mc_outdec. It is the combinational state → control-vector decoder and takes mem_ack and zero.
- The top holds only the state register, next-state logic and the sticky illegal register.

## Test plan
- R-type add (op=0110011), mem_ack tied 1 → states FETCH, DECODE, EXECR, ALUWB. reg_write=1 only in cycle 4; instr_done pulses in cycle 4.
- Load (op=0000011) with mem_ack delayed 2 cycles on each access → 9 cycles total. mem_req stays high and adr_src=1 during MEMRD; reg_write with result_src=1 comes exactly one cycle after the data ack.
- Branch (op=1100011): zero=1 → pc_write=1 in BEQ. zero=0 → pc_write=0. Both cases take 3 cycles.
- Store (op=0100011) → mem_write=1 with mem_req held until ack. reg_write stays 0 throughout.
- Illegal op 1111111 → TRAP, illegal=1 held for 20+ cycles with no strobes. rst → illegal=0, FETCH.
- rst asserted in MEMRD with mem_ack low → next cycle all outputs 0. After release, mem_req=1 with adr_src=0 (fresh fetch).

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: shared constants for the multi-cycle RISC-V controller.
//   - state_t    : controller state enum (4-bit)
//   - OP_*       : supported 7-bit opcodes
//   - ASRC_/BSRC_/ALUOP_/RES_ : datapath select encodings
//   - ctrl_t     : control vector produced by the output decoder
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_LUIWB  = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ASRC_PC    = 2'd0;
  localparam logic [1:0] ASRC_RS1   = 2'd1;
  localparam logic [1:0] ASRC_OLDPC = 2'd2;

  localparam logic [1:0] BSRC_RS2  = 2'd0;
  localparam logic [1:0] BSRC_IMM  = 2'd1;
  localparam logic [1:0] BSRC_FOUR = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_IMM = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       mem_read;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/riscv_mc_outdec.sv
// riscv_mc_outdec: combinational state -> control-vector decoder.
//   state_i   : current controller state
//   mem_ack_i : memory completed the request this cycle
//   zero_i    : ALU zero flag (branch taken)
//   ctrl_o    : datapath strobes and selects
module riscv_mc_outdec
  import riscv_mc_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ack_i,
  input  logic   zero_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_a = ASRC_PC;
        ctrl_o.alu_src_b = BSRC_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        // IR captures the returned word and PC takes PC+4 on the same edge
        ctrl_o.ir_write  = mem_ack_i;
        ctrl_o.pc_write  = mem_ack_i;
      end
      S_DECODE: begin
        // Precompute branch target from the old PC while decoding
        ctrl_o.alu_src_a = ASRC_OLDPC;
        ctrl_o.alu_src_b = BSRC_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = ASRC_RS1;
        ctrl_o.alu_src_b = BSRC_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.mem_read = 1'b1;
        ctrl_o.adr_src  = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_MEM;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.instr_done = mem_ack_i;
      end
      S_EXECR: begin
        ctrl_o.alu_src_a = ASRC_RS1;
        ctrl_o.alu_src_b = BSRC_RS2;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl_o.alu_src_a = ASRC_RS1;
        ctrl_o.alu_src_b = BSRC_IMM;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_ALU;
        ctrl_o.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a  = ASRC_RS1;
        ctrl_o.alu_src_b  = BSRC_RS2;
        ctrl_o.alu_op     = ALUOP_SUB;
        ctrl_o.pc_write   = zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      S_LUIWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_IMM;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;  // TRAP and unused encodings: no strobes
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle RISC-V control FSM for a shared memory port.
//   clk, rst        : clock, synchronous active-high reset
//   op              : opcode from the instruction register
//   zero            : ALU zero flag for branches
//   mem_ack         : memory handshake completion
//   mem_req/read/write, adr_src : memory request controls
//   ir_write, pc_write, reg_write : architectural state strobes
//   alu_src_a/b, alu_op, result_src : datapath selects
//   instr_done      : pulse in last cycle of each instruction
//   illegal         : sticky unsupported-opcode flag
module riscv_mc_ctrl
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_write,
  output logic       mem_read,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic       illegal
);

  state_t state_q, state_d;
  logic   illegal_q;
  ctrl_t  ctrl, ctrl_g;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_LUI:            state_d = S_LUIWB;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ack) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ack) state_d = S_FETCH;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_LUIWB: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  riscv_mc_outdec u_outdec (
    .state_i   (state_q),
    .mem_ack_i (mem_ack),
    .zero_i    (zero),
    .ctrl_o    (ctrl)
  );

  // Reset kills every strobe in the same cycle, abandoning any open request
  assign ctrl_g     = rst ? '0 : ctrl;
  assign mem_req    = ctrl_g.mem_req;
  assign mem_write  = ctrl_g.mem_write;
  assign mem_read   = ctrl_g.mem_read;
  assign adr_src    = ctrl_g.adr_src;
  assign ir_write   = ctrl_g.ir_write;
  assign pc_write   = ctrl_g.pc_write;
  assign reg_write  = ctrl_g.reg_write;
  assign alu_src_a  = ctrl_g.alu_src_a;
  assign alu_src_b  = ctrl_g.alu_src_b;
  assign alu_op     = ctrl_g.alu_op;
  assign result_src = ctrl_g.result_src;
  assign instr_done = ctrl_g.instr_done;
  assign illegal    = illegal_q & ~rst;

endmodule
